// File: rtl/plic_claim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : plic_claim_ctrl
//  Purpose  : Per-hart PLIC claim/complete sequencer with priority threshold
//             masking, one-hot claim pulse generation and in-service tracking.
//  Revision : 1.0  initial release
// ============================================================================
module plic_claim_ctrl #(
    parameter int PORTS  = 4,
    parameter int ID_W   = $clog2(PORTS),
    parameter int PRIO_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              plic_pending,
    input  logic [ID_W-1:0]   plic_id,
    input  logic [PRIO_W-1:0] plic_prio,
    output logic [PORTS-1:0]  int_claim,
    output logic              cpu_irq,
    input  logic              thresh_we,
    input  logic [PRIO_W-1:0] thresh_wdata,
    output logic [PRIO_W-1:0] threshold,
    input  logic              claim_req,
    output logic              claim_ack,
    output logic [ID_W:0]     claim_data,
    input  logic              complete_valid,
    input  logic [ID_W:0]     complete_data,
    output logic              busy,
    output logic              err
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    localparam logic [ID_W:0] C_ID_ONE = {{ID_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ID_W:0]       sid_q, sid_d;
    logic [PORTS-1:0]    int_claim_q, int_claim_d;
    logic                cpu_irq_q, cpu_irq_d;
    logic                ack_q, ack_d;
    logic [ID_W:0]       data_q, data_d;
    logic [PRIO_W-1:0]   thresh_q, thresh_d;
    logic                err_q, err_d;

    logic                eligible;
    logic                cmpl_match;
    logic [ID_W:0]       claim_id;
    logic [PORTS-1:0]    claim_onehot;

    // Strictly greater: priority 0 and priority == threshold are both masked.
    assign eligible   = plic_pending && (plic_prio > thresh_q);
    assign claim_id   = {1'b0, plic_id} + C_ID_ONE;
    assign cmpl_match = (state_q == ST_SERVICE) && (complete_data == sid_q);

    for (genvar i = 0; i < PORTS; i++) begin : g_onehot
        assign claim_onehot[i] = (plic_id == ID_W'(i));
    end

    always_comb begin
        state_d     = state_q;
        sid_d       = sid_q;
        int_claim_d = '0;
        ack_d       = 1'b0;
        data_d      = data_q;
        thresh_d    = thresh_q;
        err_d       = err_q;
        cpu_irq_d   = (state_q == ST_IDLE) && eligible && !claim_req;

        if (thresh_we) begin
            thresh_d = thresh_wdata;
        end

        if (complete_valid) begin
            if (cmpl_match) begin
                state_d = ST_IDLE;
                sid_d   = '0;
            end else begin
                err_d = 1'b1;
            end
        end

        // Claims only succeed from IDLE; a claim colliding with completion
        // in SERVICE sees the old state and returns 0.
        if (claim_req) begin
            ack_d = 1'b1;
            if ((state_q == ST_IDLE) && eligible) begin
                state_d     = ST_SERVICE;
                sid_d       = claim_id;
                data_d      = claim_id;
                int_claim_d = claim_onehot;
            end else begin
                data_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sid_q       <= '0;
            int_claim_q <= '0;
            cpu_irq_q   <= 1'b0;
            ack_q       <= 1'b0;
            data_q      <= '0;
            thresh_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sid_q       <= sid_d;
            int_claim_q <= int_claim_d;
            cpu_irq_q   <= cpu_irq_d;
            ack_q       <= ack_d;
            data_q      <= data_d;
            thresh_q    <= thresh_d;
            err_q       <= err_d;
        end
    end

    assign int_claim  = int_claim_q;
    assign cpu_irq    = cpu_irq_q;
    assign claim_ack  = ack_q;
    assign claim_data = data_q;
    assign threshold  = thresh_q;
    assign busy       = (state_q == ST_SERVICE);
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_plic_claim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plic_claim_ctrl
//  Purpose  : Self-checking bench for plic_claim_ctrl with a PLIC stand-in
//             and a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_plic_claim_ctrl;

    logic       clk;
    logic       rst_n;
    logic       plic_pending;
    logic [1:0] plic_id;
    logic [2:0] plic_prio;
    logic [3:0] int_claim;
    logic       cpu_irq;
    logic       thresh_we;
    logic [2:0] thresh_wdata;
    logic [2:0] threshold;
    logic       claim_req;
    logic       claim_ack;
    logic [2:0] claim_data;
    logic       complete_valid;
    logic [2:0] complete_data;
    logic       busy;
    logic       err;

    plic_claim_ctrl #(.PORTS(4), .PRIO_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .plic_pending   (plic_pending),
        .plic_id        (plic_id),
        .plic_prio      (plic_prio),
        .int_claim      (int_claim),
        .cpu_irq        (cpu_irq),
        .thresh_we      (thresh_we),
        .thresh_wdata   (thresh_wdata),
        .threshold      (threshold),
        .claim_req      (claim_req),
        .claim_ack      (claim_ack),
        .claim_data     (claim_data),
        .complete_valid (complete_valid),
        .complete_data  (complete_data),
        .busy           (busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // PLIC stand-in: per-source pending flags and priorities.
    logic src_pend [4];
    int   prio_tab [4];

    // Reference model state.
    int   m_serv;
    int   m_thr;
    int   m_data;
    logic m_err;
    logic m_irq;
    logic m_ack;
    logic [3:0] m_claim;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_plic();
        int best;
        best = -1;
        for (int i = 0; i < 4; i++) begin
            if (src_pend[i] && (best < 0 || prio_tab[i] > prio_tab[best])) best = i;
        end
        plic_pending = (best >= 0);
        plic_id      = (best >= 0) ? 2'(best) : 2'd0;
        plic_prio    = (best >= 0) ? 3'(prio_tab[best]) : 3'd0;
    endtask

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic cyc();
        drive_plic();
        @(posedge clk);
        @(negedge clk);
        claim_req      = 1'b0;
        complete_valid = 1'b0;
        thresh_we      = 1'b0;
        drive_plic();
    endtask

    task automatic do_claim(input int exp_data, input logic [3:0] exp_vec, input string nm);
        claim_req = 1'b1;
        cyc();
        chk({nm, "_ack"}, 32'(claim_ack), 32'd1);
        chk({nm, "_data"}, 32'(claim_data), 32'(exp_data));
        chk({nm, "_pulse"}, 32'(int_claim), 32'(exp_vec));
    endtask

    task automatic do_complete(input int id);
        complete_valid = 1'b1;
        complete_data  = 3'(id);
        cyc();
    endtask

    // Behavioural model and the single per-cycle compare process.
    always @(posedge clk or negedge rst_n) begin
        int   old_serv;
        logic elig;
        if (!rst_n) begin
            m_serv = 0; m_thr = 0; m_data = 0; m_err = 1'b0;
            m_irq = 1'b0; m_ack = 1'b0; m_claim = 4'd0;
        end else begin
            old_serv = m_serv;
            elig     = plic_pending && (int'(plic_prio) > m_thr);
            m_irq    = (old_serv == 0) && elig && !claim_req;
            m_ack    = claim_req;
            m_claim  = 4'd0;
            if (complete_valid) begin
                if (old_serv != 0 && int'(complete_data) == old_serv) m_serv = 0;
                else m_err = 1'b1;
            end
            if (claim_req) begin
                if (old_serv == 0 && elig) begin
                    m_data  = int'(plic_id) + 1;
                    m_serv  = m_data;
                    m_claim[plic_id] = 1'b1;
                end else begin
                    m_data = 0;
                end
            end
            if (thresh_we) m_thr = int'(thresh_wdata);
        end
        #1;
        chk("int_claim", 32'(int_claim), 32'(m_claim));
        chk("cpu_irq", 32'(cpu_irq), 32'(m_irq));
        chk("claim_ack", 32'(claim_ack), 32'(m_ack));
        chk("claim_data", 32'(claim_data), 32'(m_data));
        chk("threshold", 32'(threshold), 32'(m_thr));
        chk("busy", 32'(busy), 32'(m_serv != 0));
        chk("err", 32'(err), 32'(m_err));
        if (rst_n) begin
            for (int i = 0; i < 4; i++) if (m_claim[i]) src_pend[i] = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0;
        claim_req = 1'b0; complete_valid = 1'b0; complete_data = 3'd0;
        thresh_we = 1'b0; thresh_wdata = 3'd0;
        prio_tab[0] = 3; prio_tab[1] = 2; prio_tab[2] = 4; prio_tab[3] = 1;
        for (int i = 0; i < 4; i++) src_pend[i] = 1'b0;
        drive_plic();
        @(negedge clk);
        repeat (2) cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_thr", 32'(threshold), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Case 1: all four sources raised, threshold 0.
        for (int i = 0; i < 4; i++) src_pend[i] = 1'b1;
        cyc();
        chk("c1_irq", 32'(cpu_irq), 32'd1);
        do_claim(3, 4'b0100, "c1");
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_irq_low", 32'(cpu_irq), 32'd0);
        cyc();
        chk("c1_pulse_end", 32'(int_claim), 32'd0);

        // Case 2: complete 3, then drain the rest in priority order.
        do_complete(3);
        chk("c2_busy", 32'(busy), 32'd0);
        cyc();
        chk("c2_irq", 32'(cpu_irq), 32'd1);
        do_claim(1, 4'b0001, "c2a"); do_complete(1); cyc();
        do_claim(2, 4'b0010, "c2b"); do_complete(2); cyc();
        do_claim(4, 4'b1000, "c2c"); do_complete(4); cyc();

        // Case 3: threshold masking with prio == threshold.
        thresh_we = 1'b1; thresh_wdata = 3'd3;
        cyc();
        src_pend[0] = 1'b1; src_pend[3] = 1'b1;
        cyc(); cyc();
        chk("c3_irq_masked", 32'(cpu_irq), 32'd0);
        do_claim(0, 4'b0000, "c3_masked");
        thresh_we = 1'b1; thresh_wdata = 3'd2;
        cyc(); cyc();
        chk("c3_irq", 32'(cpu_irq), 32'd1);
        do_claim(1, 4'b0001, "c3");
        do_complete(1);
        src_pend[3] = 1'b0;
        thresh_we = 1'b1; thresh_wdata = 3'd0;
        cyc();

        // Case 4: wrong-ID completion sets sticky err.
        src_pend[2] = 1'b1;
        cyc();
        do_claim(3, 4'b0100, "c4");
        do_complete(2);
        chk("c4_err", 32'(err), 32'd1);
        chk("c4_busy", 32'(busy), 32'd1);
        do_complete(3);
        chk("c4_idle", 32'(busy), 32'd0);
        chk("c4_err_sticky", 32'(err), 32'd1);

        // Case 5: claim and matching completion in the same cycle.
        src_pend[1] = 1'b1;
        cyc();
        do_claim(2, 4'b0010, "c5a");
        src_pend[0] = 1'b1;
        complete_valid = 1'b1; complete_data = 3'd2;
        do_claim(0, 4'b0000, "c5b");
        chk("c5_busy", 32'(busy), 32'd0);

        // Case 6: reset during the claim_ack cycle.
        thresh_we = 1'b1; thresh_wdata = 3'd1;
        cyc(); cyc();
        claim_req = 1'b1;
        drive_plic();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        claim_req = 1'b0;
        #2;
        chk("c6_ack", 32'(claim_ack), 32'd0);
        chk("c6_pulse", 32'(int_claim), 32'd0);
        chk("c6_data", 32'(claim_data), 32'd0);
        chk("c6_thr", 32'(threshold), 32'd0);
        chk("c6_busy_err", 32'({busy, err, cpu_irq}), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) src_pend[i] = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("c6_no_pulse", 32'(int_claim), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 600 == 0) begin
                rst_n = 1'b0;
                for (int i = 0; i < 4; i++) src_pend[i] = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            if ($urandom % 6 == 0) src_pend[$urandom % 4] = 1'b1;
            if ($urandom % 200 == 0) begin
                for (int i = 0; i < 4; i++) prio_tab[i] = int'($urandom % 8);
            end
            claim_req      = ($urandom % 4 == 0);
            complete_valid = ($urandom % 6 == 0);
            complete_data  = ($urandom % 4 != 0) ? 3'(m_serv) : 3'($urandom % 8);
            thresh_we      = ($urandom % 20 == 0);
            thresh_wdata   = 3'($urandom % 6);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
